// File: rtl/exec_sequencer.sv
// Four-phase instruction sequencer (FETCH/DECODE/EXEC/WB) driving ROM, accumulator and register strobes.
// Define SEQ_JUMP_EN to enable JMP (opcode 4'b1110); otherwise JMP executes as NOP.
module exec_sequencer #(
    parameter int PROG_LEN = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  logic        step_req,
    input  logic [15:0] cell_data,
    output logic [4:0]  prog_cnt,
    output logic        rom_oe,
    output logic [15:0] ir,
    output logic        load_en,
    output logic        store_en,
    output logic        R0_ce,
    output logic        R1_ce,
    output logic        R0_oe,
    output logic        R1_oe,
    output logic        acu_we,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0]  OP_LD   = 4'b1010;
    localparam logic [3:0]  OP_ST   = 4'b1011;
    localparam logic [3:0]  OP_NOP  = 4'b1100;
    localparam logic [3:0]  OP_JMP  = 4'b1110;
    localparam logic [3:0]  OP_HALT = 4'b1111;
    localparam logic [15:0] IR_NOP  = 16'h0C00;
    localparam logic [4:0]  PC_LAST = 5'(PROG_LEN - 1);

    state_t     state, state_nxt;
    logic [3:0] opcode;
    logic       is_alu;
    logic       st_bad;
    logic       jmp_err;
    logic [4:0] pc_inc;
    logic [4:0] pc_nxt;

    assign opcode = ir[11:8];
    assign is_alu = !(opcode inside {OP_LD, OP_ST, OP_NOP, OP_JMP, OP_HALT});
    // A store must select exactly one register; 00 and 11 are flagged, not executed.
    assign st_bad = (opcode == OP_ST) && (ir[13] == ir[12]);
    assign pc_inc = (prog_cnt == PC_LAST) ? 5'd0 : prog_cnt + 5'd1;

`ifdef SEQ_JUMP_EN
    logic jmp_ok;
    assign jmp_ok  = 32'(ir[4:0]) < PROG_LEN;
    assign jmp_err = (opcode == OP_JMP) && !jmp_ok;
    assign pc_nxt  = (opcode != OP_JMP) ? pc_inc : (jmp_ok ? ir[4:0] : 5'd0);
`else
    assign jmp_err = 1'b0;
    assign pc_nxt  = pc_inc;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            ir       <= IR_NOP;
            prog_cnt <= 5'd0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH) begin
                ir <= cell_data;
            end
            if (state == S_WB) begin
                prog_cnt <= pc_nxt;
                if (st_bad || jmp_err) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = S_IDLE;
        rom_oe    = 1'b0;
        load_en   = 1'b0;
        store_en  = 1'b0;
        R0_ce     = 1'b0;
        R1_ce     = 1'b0;
        R0_oe     = 1'b0;
        R1_oe     = 1'b0;
        acu_we    = 1'b0;
        case (state)
            S_IDLE:   state_nxt = (run || step_req) ? S_FETCH : S_IDLE;
            S_FETCH: begin
                rom_oe    = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: state_nxt = (opcode == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                acu_we    = !(opcode inside {OP_NOP, OP_ST, OP_JMP});
                load_en   = (opcode == OP_LD);
                R0_oe     = is_alu && ir[12];
                R1_oe     = is_alu && ir[13];
                state_nxt = S_WB;
            end
            S_WB: begin
                store_en  = (opcode == OP_ST) && !st_bad;
                R0_ce     = store_en && ir[12];
                R1_ce     = store_en && ir[13];
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a small ROM model feeds cell_data from prog_cnt.
// Strobe vector order: {load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, acu_we}.
module tb_exec_sequencer;

    logic        clk;
    logic        rstn;
    logic        run;
    logic        step_req;
    logic [15:0] cell_data;
    logic [4:0]  prog_cnt;
    logic        rom_oe;
    logic [15:0] ir;
    logic        load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, acu_we;
    logic        halted;
    logic        err;
    logic [2:0]  state_dbg;
    logic [6:0]  strb;
    logic [15:0] rom [0:31];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    exec_sequencer #(.PROG_LEN(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .step_req  (step_req),
        .cell_data (cell_data),
        .prog_cnt  (prog_cnt),
        .rom_oe    (rom_oe),
        .ir        (ir),
        .load_en   (load_en),
        .store_en  (store_en),
        .R0_ce     (R0_ce),
        .R1_ce     (R1_ce),
        .R0_oe     (R0_oe),
        .R1_oe     (R1_oe),
        .acu_we    (acu_we),
        .halted    (halted),
        .err       (err),
        .state_dbg (state_dbg)
    );

    assign cell_data = rom[prog_cnt];
    assign strb      = {load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe, acu_we};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rom_fill_nop();
        for (int i = 0; i < 32; i++) rom[i] = 16'h0C00;
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    initial begin
        rstn     = 1'b0;
        run      = 1'b0;
        step_req = 1'b0;
        rom_fill_nop();
        tick(2);

        // Reset values
        check("rst_state",  16'(state_dbg), 16'd0);
        check("rst_pc",     16'(prog_cnt),  16'd0);
        check("rst_ir",     ir,             16'h0C00);
        check("rst_halted", 16'(halted),    16'd0);
        check("rst_err",    16'(err),       16'd0);
        check("rst_rom_oe", 16'(rom_oe),    16'd0);
        check("rst_strb",   16'(strb),      16'd0);
        rstn = 1'b1;
        tick(3);
        check("idle_no_run", 16'(state_dbg), 16'd0);

        // LD 5 / ST R0 / ADD R0 2 under run; cycle 1 is the first FETCH
        rom[0] = 16'h0A05;
        rom[1] = 16'h1B00;
        rom[2] = 16'h1002;
        run = 1'b1;
        tick(1);
        check("c1_fetch",   16'(state_dbg), 16'd1);
        check("c1_rom_oe",  16'(rom_oe),    16'd1);
        tick(1);
        check("c2_ir",      ir,             16'h0A05);
        tick(1);
        check("c3_ld_strb", 16'(strb),      16'(7'b1000001));
        tick(1);
        check("c4_wb_strb", 16'(strb),      16'd0);
        tick(4);
        check("c8_st_strb", 16'(strb),      16'(7'b0110000));
        tick(3);
        check("c11_add",    16'(strb),      16'(7'b0000101));
        tick(1);
        check("c12_pc",     16'(prog_cnt),  16'd2);
        tick(1);
        check("c13_pc",     16'(prog_cnt),  16'd3);
        check("c13_fetch",  16'(state_dbg), 16'd1);
        run = 1'b0;
        tick(4);
        check("stop_idle",  16'(state_dbg), 16'd0);
        check("stop_pc",    16'(prog_cnt),  16'd4);

        // Single-stepping; a step pulse mid-instruction is ignored
        rom_fill_nop();
        do_reset();
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        check("step1_fetch", 16'(state_dbg), 16'd1);
        tick(1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(2);
        check("step1_idle", 16'(state_dbg), 16'd0);
        check("step1_pc",   16'(prog_cnt),  16'd1);
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        tick(4);
        tick(3);
        check("step2_idle", 16'(state_dbg), 16'd0);
        check("step2_pc",   16'(prog_cnt),  16'd2);

        // PC wrap 15 -> 0 with no gap
        do_reset();
        run = 1'b1;
        tick(61);
        check("wrap_pc15",    16'(prog_cnt),  16'd15);
        check("wrap_fetch15", 16'(state_dbg), 16'd1);
        tick(3);
        check("wrap_wb",      16'(state_dbg), 16'd4);
        tick(1);
        check("wrap_pc0",     16'(prog_cnt),  16'd0);
        check("wrap_fetch0",  16'(state_dbg), 16'd1);
        run = 1'b0;
        tick(4);
        check("wrap_end_pc",  16'(prog_cnt),  16'd1);

        // HALT at address 4
        rom[4] = 16'h0F00;
        do_reset();
        run = 1'b1;
        tick(18);
        check("pre_halt_state",  16'(state_dbg), 16'd2);
        check("pre_halt_halted", 16'(halted),    16'd0);
        tick(1);
        check("halt_state",  16'(state_dbg), 16'd5);
        check("halt_halted", 16'(halted),    16'd1);
        run      = 1'b0;
        step_req = 1'b1;
        tick(1);
        step_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("halt_pc",   16'(prog_cnt), 16'd4);
            check("halt_strb", 16'({strb, rom_oe, halted}), 16'(9'b000000001));
        end

        // Illegal ST (11), then LD, ST R1, ADD; reset during the ADD EXEC
        rom_fill_nop();
        rom[0] = 16'h3B00;
        rom[1] = 16'h0A05;
        rom[2] = 16'h2B00;
        rom[3] = 16'h1002;
        do_reset();
        run = 1'b1;
        tick(3);
        check("stbad_exec", 16'(strb), 16'd0);
        tick(1);
        check("stbad_wb",   16'(strb), 16'd0);
        check("stbad_err0", 16'(err),  16'd0);
        tick(1);
        check("stbad_err1",  16'(err),       16'd1);
        check("stbad_pc",    16'(prog_cnt),  16'd1);
        check("stbad_fetch", 16'(state_dbg), 16'd1);
        tick(1);
        check("next_ir",    ir,        16'h0A05);
        tick(1);
        check("next_ld",    16'(strb), 16'(7'b1000001));
        tick(5);
        check("st_r1_wb",   16'(strb), 16'(7'b0101000));
        tick(3);
        check("add_exec",   16'(strb), 16'(7'b0000101));
        check("err_sticky", 16'(err),  16'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("arst_state",  16'(state_dbg), 16'd0);
        check("arst_pc",     16'(prog_cnt),  16'd0);
        check("arst_ir",     ir,             16'h0C00);
        check("arst_err",    16'(err),       16'd0);
        check("arst_halted", 16'(halted),    16'd0);
        check("arst_strb",   16'({strb, rom_oe}), 16'd0);
        tick(2);
        check("arst_hold_strb",  16'(strb),      16'd0);
        check("arst_hold_state", 16'(state_dbg), 16'd0);
        run  = 1'b0;
        rstn = 1'b1;
        tick(2);
        check("post_rst_idle", 16'(state_dbg), 16'd0);

        // JMP 7 (and JMP 20 out of range when jumps are enabled)
        rom_fill_nop();
        rom[0] = 16'h0E07;
        rom[7] = 16'h0E14;
        do_reset();
        run = 1'b1;
        tick(3);
        check("jmp_exec_strb", 16'(strb), 16'd0);
        tick(2);
`ifdef SEQ_JUMP_EN
        check("jmp_pc7",    16'(prog_cnt), 16'd7);
        check("jmp_err0",   16'(err),      16'd0);
        tick(4);
        check("jmp_oob_pc", 16'(prog_cnt), 16'd0);
        check("jmp_oob_err", 16'(err),     16'd1);
`else
        check("jmp_nop_pc1", 16'(prog_cnt), 16'd1);
        check("jmp_nop_err", 16'(err),      16'd0);
        tick(4);
        check("jmp_nop_pc2", 16'(prog_cnt), 16'd2);
`endif
        run = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter PROG_LEN, default 16: number of valid program words; PC wraps at PROG_LEN-1.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 run  input  1  level; 1 = execute instructions continuously.
REQ-005 step_req  input  1  one-cycle pulse; executes one instruction when idle and run=0.
REQ-006 cell_data  input  16  program word: [13] R1 sel, [12] R0 sel, [11:8] opcode, [7:0] data.
REQ-007 prog_cnt  output  5  program counter driving the ROM address.
REQ-008 rom_oe  output  1  ROM output enable.
REQ-009 ir  output  16  latched instruction register.
REQ-010 load_en, store_en  output  1 each  accumulator-load and register-store strobes.
REQ-011 R0_ce, R1_ce, R0_oe, R1_oe  output  1 each  register write and read selects.
REQ-012 acu_we  output  1  accumulator update strobe.
REQ-013 halted  output  1  sticky halt indication.
REQ-014 err  output  1  sticky illegal-instruction flag.
REQ-015 state_dbg  output  3  current FSM state encoding.

Function
REQ-016 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6 and 7 return to IDLE on the next edge.
REQ-017 IDLE SHALL go to FETCH when run=1 or step_req=1; otherwise it stays in IDLE.
REQ-018 FETCH: rom_oe=1, ir<=cell_data on the exit edge; the next state is DECODE.
REQ-019 DECODE: opcode 4'b1111 (HALT) SHALL go to HALT; any other opcode goes to EXEC.
REQ-020 EXEC: acu_we=1 for every opcode except NOP (4'b1100), ST (4'b1011) and JMP.
- load_en=1 for LD (4'b1010).
- R0_oe=ir[12] and R1_oe=ir[13] for ALU opcodes (all opcodes other than LD/ST/NOP/JMP/HALT).
- The next state is WB.
REQ-021 WB: for ST, store_en=1 with R0_ce=ir[12] and R1_ce=ir[13].
- prog_cnt SHALL update on the WB exit edge: PC+1, with PROG_LEN-1 wrapping to 0.
- The next state is FETCH if run=1, else IDLE.
REQ-022 Throughput SHALL be exactly 4 clk cycles per instruction, with no idle gap under continuous run.
REQ-023 All strobes not listed for the current state SHALL be 0; every strobe is a single-cycle pulse.
REQ-024 ST with ir[13:12] of 2'b00 or 2'b11 SHALL NOT assert store_en, R0_ce or R1_ce; it SHALL set err=1, and execution continues.
REQ-025 step_req SHALL be ignored unless the FSM is in IDLE with run=0.
- A step executes one instruction and returns to IDLE.
REQ-026 If run is deasserted mid-instruction, the current instruction SHALL complete through WB, and the FSM then enters IDLE.
REQ-027 HALT SHALL set halted=1; HALT is sticky until rstn.
- prog_cnt stays frozen at the HALT instruction address.
- All strobes stay at 0.
REQ-028 run=1 and step_req=1 in the same IDLE cycle SHALL behave as run.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE and prog_cnt=0, ir=16'h0C00 (NOP), halted=0, err=0, with all strobes and rom_oe at 0.
REQ-030 Reset asserted mid-instruction SHALL abort that instruction with no store_en or acu_we pulse after the reset edge.
REQ-031 After rstn deasserts, the first FETCH SHALL occur no earlier than the first rising edge with run=1 or step_req=1.

Configuration
REQ-032 Macro SEQ_JUMP_EN, when defined, makes opcode 4'b1110 (JMP) load prog_cnt<=ir[4:0] on the WB exit edge instead of PC+1.
- A target of PROG_LEN or more SHALL load 0 and set err=1.
REQ-033 Without SEQ_JUMP_EN, opcode 4'b1110 SHALL execute as NOP.
- PC+1 applies, and no strobes are asserted.

Verification
REQ-034 The bench SHALL cover: program LD 5 / ST R0 / ADD R0 2 with run=1 -> load_en in cycle 3, store_en+R0_ce in cycle 8, acu_we in cycle 11, prog_cnt=3 after 12 cycles.
REQ-035 The bench SHALL cover: run=0 with step_req pulsed twice -> exactly two instructions complete, prog_cnt=2, state_dbg=0.
REQ-036 The bench SHALL cover: word 15 = NOP under continuous run -> prog_cnt wraps 15->0 with no extra cycle.
REQ-037 The bench SHALL cover: HALT at address 4 -> halted=1, prog_cnt=4 held for 20 cycles, and step_req has no effect.
REQ-038 The bench SHALL cover: ST with ir[13:12]=2'b11 -> no store_en, err=1, and the next instruction fetched normally.
REQ-039 The bench SHALL cover: rstn low during EXEC of an ADD -> no acu_we, all outputs at their REQ-029 values; with SEQ_JUMP_EN defined, JMP 7 -> prog_cnt=7.
